// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: segment codes,
// decimal-point bit position and the scan controller state encoding.
package seg_pkg;

  localparam int SEG_DP = 7;

  // Segment bit order is g..a in bits [6:0]
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_e;

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit hex value to 7-segment (g..a) pattern decoder.
module seg7_dec
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_CODE[val_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display with
// inter-digit blanking, per-digit decimal points and leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int DWELL       = 1000,
  parameter int BLANK       = 8,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              lzb,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_in,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   sel,
  output logic              frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0]   DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0]   BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] SEL_OFF  = {NDIG{SEL_ACT_LOW}};

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] snap_q, snap_d;
  logic [7:0]        seg_q, seg_d;
  logic [NDIG-1:0]   sel_q, sel_d;
  logic              fd_q, fd_d;
  logic              load;

  logic [3:0]        nib;
  logic [6:0]        dec_seg;
  logic [NDIG-1:0]   lz_mask;
  logic              zero_above;
  logic [NDIG-1:0]   sel_on;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    fd_d    = 1'b0;
    load    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      load    = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          snap_d = digits;
          idx_d  = '0;
          load   = 1'b1;
          if (BLANK == 0) begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
          end else begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
          end
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == '0) begin
            load = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d  = '0;
              fd_d   = 1'b1;
              snap_d = digits;
            end else begin
              idx_d = idx_q + 1'b1;
            end
            if (BLANK == 0) begin
              state_d = S_SHOW;
              cnt_d   = DWELL_LD;
            end else begin
              state_d = S_BLANK;
              cnt_d   = BLANK_LD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Display data is taken from the snapshot being loaded on this edge, so a
  // recapture at frame end is already visible on the first digit.
  assign nib = snap_d[{idx_d, 2'b00} +: 4];

  seg7_dec u_dec (
    .val_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    zero_above = lzb;
    lz_mask    = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above = zero_above && (snap_d[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  always_comb begin
    sel_on        = '0;
    sel_on[idx_d] = 1'b1;
    seg_d         = 8'h00;
    sel_d         = SEL_OFF;
    if (state_d == S_SHOW) begin
      seg_d[SEG_DP]  = dp_in[idx_d];
      seg_d[6:0]     = lz_mask[idx_d] ? 7'h00 : dec_seg;
      sel_d          = sel_on ^ SEL_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      seg_q   <= 8'h00;
      sel_q   <= SEL_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      fd_q    <= fd_d;
      if (load) begin
        seg_q <= seg_d;
        sel_q <= sel_d;
      end
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with NDIG=4, DWELL=4, BLANK=2, active-low sel.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        lzb;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame_done;

  int   checks;
  int   errors;
  exp_t q[$];

  seg_scan_ctrl #(
    .NDIG        (4),
    .DWELL       (4),
    .BLANK       (2),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lzb        (lzb),
    .digits     (digits),
    .dp_in      (dp_in),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One frame: per digit 2 blank cycles then 4 lit cycles; segs[8d+:8] is digit d.
  // frame_done shows on the first blank cycle after a completed frame.
  task automatic push_frame(input logic [31:0] segs, input bit first);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int b = 0; b < 2; b++) begin
        e.sel = 4'hF;
        e.seg = 8'h00;
        e.fd  = (d == 0 && b == 0 && !first);
        q.push_back(e);
      end
      for (int s = 0; s < 4; s++) begin
        e.sel = ~(4'b0001 << d);
        e.seg = segs[8*d +: 8];
        e.fd  = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.sel = 4'hF;
    e.seg = 8'h00;
    e.fd  = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; en = 1'b0; lzb = 1'b0; digits = 16'h0000; dp_in = 4'h0;
    #12;
    checks++;
    if (seg !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", seg); end
    checks++;
    if (sel !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h want f", sel); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    @(negedge clk);
    rst = 1'b1;
    push_idle(2);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL idle cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
  endtask

  task automatic test_scan();
    exp_t e;
    @(negedge clk);
    digits = 16'h1234; lzb = 1'b0; dp_in = 4'h0; en = 1'b1;
    push_frame(32'h065b4f66, 1'b1);
    push_frame(32'h065b4f66, 1'b0);
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL scan cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_lzb();
    exp_t e;
    @(negedge clk);
    digits = 16'h0050; lzb = 1'b1; en = 1'b1;
    push_frame(32'h00006d3f, 1'b1);
    push_frame(32'h0000003f, 1'b0);
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL lzb cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
      if (i == 0) digits = 16'h0000;
    end
    @(negedge clk);
    en = 1'b0; lzb = 1'b0;
  endtask

  task automatic test_hex_dp();
    exp_t e;
    @(negedge clk);
    digits = 16'hABEF; dp_in = 4'b0001; en = 1'b1;
    push_frame(32'h777c79f1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL hexdp cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    @(negedge clk);
    en = 1'b0; dp_in = 4'h0;
  endtask

  task automatic test_snapshot();
    exp_t e;
    @(negedge clk);
    digits = 16'h1234; en = 1'b1;
    push_frame(32'h065b4f66, 1'b1);
    push_frame(32'h6f6f6f6f, 1'b0);
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL snapshot cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
      if (i == 9) digits = 16'h9999;
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    @(negedge clk);
    digits = 16'h1234; en = 1'b1;
    push_frame(32'h065b4f66, 1'b1);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL abort_run cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    // en drops on the last cycle of the last digit: no frame_done may follow
    @(negedge clk);
    en = 1'b0;
    push_idle(2);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL abort_off cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    @(negedge clk);
    en = 1'b1;
    push_frame(32'h065b4f66, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL abort_resume cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    q.delete();
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    digits = 16'h1234; en = 1'b1;
    push_frame(32'h065b4f66, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL rstmid_run cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    q.delete();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (seg !== 8'h00) begin errors++; $display("FAIL rstmid_seg: got %h want 00", seg); end
    checks++;
    if (sel !== 4'hF) begin errors++; $display("FAIL rstmid_sel: got %h want f", sel); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fd: got %b want 0", frame_done); end
    @(negedge clk);
    rst = 1'b1;
    push_frame(32'h065b4f66, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({sel, seg, frame_done} !== {e.sel, e.seg, e.fd}) begin
        errors++;
        $display("FAIL rstmid_restart cyc %0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                 i, sel, seg, frame_done, e.sel, e.seg, e.fd);
      end
    end
    q.delete();
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_lzb();
    test_hex_dp();
    test_snapshot();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
